updown_sweep_ctrl: RTL and testbench
====================================

Name: updown_sweep_ctrl

Overview:
Sequencer for the up/down synchronous counter datapath. It owns the count register and the direction control. On a start request it loads a start value, then steps the count one LSB at a time toward a target value, holding each value for a programmable dwell time. It reports busy and done through a start/busy/done handshake, so a host FSM can schedule counter sweeps without driving the direction bit cycle by cycle.

Parameters:
WIDTH, 3, count width in bits
DWELL_W, 4, width of the dwell-time configuration field

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  sweep request, sampled each clk edge
abort  in  1  cancel the running sweep
cfg_start  in  WIDTH  initial count value, latched on start accept
cfg_end  in  WIDTH  target count value, latched on start accept
cfg_dwell  in  DWELL_W  each value is held for cfg_dwell+1 RUN cycles; latched on start accept
count  out  WIDTH  current count (registered)
up_down  out  1  direction: 1 = up, 0 = down (registered)
step  out  1  1-cycle pulse in the cycle after count changed by ±1
busy  out  1  high while in RUN
done  out  1  1-cycle pulse, high exactly in the DONE state

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; count=0; up_down=1; step=0; busy=0; done=0; dwell_cnt=0; latched cfg regs=0.
- States: IDLE, RUN, DONE. All outputs are registered and there are no combinational paths from inputs to outputs.
- IDLE or DONE, start=1, abort=0: latch cfg_end and cfg_dwell; count<=cfg_start; up_down<=(cfg_end>=cfg_start); dwell_cnt<=cfg_dwell; go to RUN; busy=1 after this edge.
- IDLE, start=1 and abort=1 together: abort wins; stay in IDLE; no register changes.
- RUN, each cycle, in priority order:
  1. abort=1: go to IDLE, busy<=0, count holds, no done pulse.
  2. dwell_cnt!=0: dwell_cnt decrements.
  3. dwell_cnt==0 and count!=end_q: count<=count±1 per up_down; step<=1; dwell_cnt<=dwell_q.
  4. dwell_cnt==0 and count==end_q: go to DONE; busy<=0; done<=1.
- step is 0 in every cycle not covered by rule 3.
- start is ignored while in RUN. Configuration inputs are don't-care except on the accept edge.
- DONE lasts exactly 1 cycle, then goes to IDLE unless start is accepted in that cycle (back-to-back sweeps). count keeps end_q.
- Latency: done is high (|end−start|+1)·(cfg_dwell+1) cycles after the start-accept edge.
- Arithmetic: direction always points toward the target, so count never wraps (7→0 or 0→7 never happens). Width-modular arithmetic is used, but no carry or borrow ever occurs.
- start==end: no step occurs; done after cfg_dwell+1 cycles.
- Reset asserted mid-sweep: immediate return to the reset values; no done pulse.

Optional Feature:
- Macro SWEEP_PINGPONG_EN.
- Defined: on reaching end_q, the block does not enter DONE. It inverts up_down, reloads dwell, and steps back to the start value. It enters DONE when the count equals the start value again after the return leg. done latency becomes (2·|end−start|+1)·(cfg_dwell+1). When start==end the latency is unchanged from the one-way case.
- The return leg is tracked by a 1-bit leg flag, which resets to 0.
- Not defined: one-way sweep only, as described in Behaviour. No leg flag is present.

Test Plan:
- Reset mid-sweep: cfg 1→6, dwell 3; drop rst_n for 1 cycle mid-RUN (no clock edge needed) → count=0, up_down=1, busy=0, done never pulses; a new start then works normally.
- Up sweep: cfg_start=2, cfg_end=5, dwell=0 → count 2,3,4,5 on consecutive cycles; 3 step pulses; up_down=1; done 4 cycles after accept; busy high for exactly those 4 cycles.
- Down sweep with dwell: start=6, end=1, dwell=2 → each value held 3 cycles; up_down=0; done 18 cycles after accept; count never shows 7 or 0.
- Boundaries: start=0, end=7, dwell=0 → 7 steps, no wrap, done at cycle 8. Separately, start=end=4, dwell=1 → no step, done 2 cycles after accept.
- Abort and ignored start: abort during RUN at count=3 → IDLE next edge, count stays 3, no done pulse. start asserted while busy → ignored. start+abort together in IDLE → no accept.
- Back-to-back: start held high through DONE → new sweep accepted in the DONE cycle and busy reasserts the next cycle. With SWEEP_PINGPONG_EN, 1→3, dwell 0 → count 1,2,3,2,1; done at cycle 5.

Source files
------------

// File: rtl/updown_sweep_ctrl.sv
// Up/down counter sweep sequencer with start/busy/done handshake.
// Optional return leg back to the start value: define SWEEP_PINGPONG_EN.
module updown_sweep_ctrl #(
  parameter int WIDTH   = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   cfg_start,
  input  logic [WIDTH-1:0]   cfg_end,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic [WIDTH-1:0]   count,
  output logic               up_down,
  output logic               step,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               up_q, up_d;
  logic               step_q, step_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [WIDTH-1:0]   end_q, end_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [WIDTH-1:0]   target;
  logic               accept;

`ifdef SWEEP_PINGPONG_EN
  logic [WIDTH-1:0]   start_q, start_d;
  logic               leg_q, leg_d;

  assign target = leg_q ? start_q : end_q;
`else
  assign target = end_q;
`endif

  assign accept = start && !abort;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    up_d        = up_q;
    step_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dwell_cnt_d = dwell_cnt_q;
    end_d       = end_q;
    dwell_d     = dwell_q;
`ifdef SWEEP_PINGPONG_EN
    start_d     = start_q;
    leg_d       = leg_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (accept) begin
          state_d     = S_RUN;
          busy_d      = 1'b1;
          end_d       = cfg_end;
          dwell_d     = cfg_dwell;
          count_d     = cfg_start;
          up_d        = (cfg_end >= cfg_start);
          dwell_cnt_d = cfg_dwell;
`ifdef SWEEP_PINGPONG_EN
          start_d     = cfg_start;
          leg_d       = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (dwell_cnt_q != '0) begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end else if (count_q != target) begin
          count_d     = up_q ? count_q + WIDTH'(1)
                             : count_q - WIDTH'(1);
          step_d      = 1'b1;
          dwell_cnt_d = dwell_q;
`ifdef SWEEP_PINGPONG_EN
        end else if (!leg_q && (end_q != start_q)) begin
          // turn around at the target and take the first return step
          leg_d       = 1'b1;
          up_d        = !up_q;
          count_d     = up_q ? count_q - WIDTH'(1)
                             : count_q + WIDTH'(1);
          step_d      = 1'b1;
          dwell_cnt_d = dwell_q;
`endif
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      up_q        <= 1'b1;
      step_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dwell_cnt_q <= '0;
      end_q       <= '0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      up_q        <= up_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dwell_cnt_q <= dwell_cnt_d;
      end_q       <= end_d;
      dwell_q     <= dwell_d;
    end
  end

`ifdef SWEEP_PINGPONG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      leg_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      leg_q   <= leg_d;
    end
  end
`endif

  assign count   = count_q;
  assign up_down = up_q;
  assign step    = step_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Randomized + directed bench for updown_sweep_ctrl.
// Reference model expands each sweep into its per-cycle value list.
module tb_updown_sweep_ctrl;

  localparam int W = 3;
  localparam int D = 4;
`ifdef SWEEP_PINGPONG_EN
  localparam bit PING = 1'b1;
`else
  localparam bit PING = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [W-1:0] cfg_start;
  logic [W-1:0] cfg_end;
  logic [D-1:0] cfg_dwell;
  logic [W-1:0] count;
  logic         up_down;
  logic         step;
  logic         busy;
  logic         done;

  updown_sweep_ctrl #(.WIDTH(W), .DWELL_W(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_start (cfg_start),
    .cfg_end   (cfg_end),
    .cfg_dwell (cfg_dwell),
    .count     (count),
    .up_down   (up_down),
    .step      (step),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // model: 0 idle, 1 run, 2 done
  int m_mode, m_count, m_up, m_step, m_busy, m_done;
  int seq[$];
  int dirq[$];
  int lat_cnt, lat_exp;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_count = 0;
    m_up    = 1;
    m_step  = 0;
    m_busy  = 0;
    m_done  = 0;
    seq.delete();
    dirq.delete();
  endtask

  task automatic build(int s, int e, int d);
    int n, up0, v;
    n   = (e >= s) ? e - s : s - e;
    up0 = (e >= s) ? 1 : 0;
    seq.delete();
    dirq.delete();
    for (int i = 0; i <= n; i++) begin
      v = up0 ? s + i : s - i;
      for (int k = 0; k <= d; k++) begin
        seq.push_back(v);
        dirq.push_back(up0);
      end
    end
    if (PING && n > 0) begin
      for (int i = 1; i <= n; i++) begin
        v = up0 ? e - i : e + i;
        for (int k = 0; k <= d; k++) begin
          seq.push_back(v);
          dirq.push_back(1 - up0);
        end
      end
    end
    lat_exp = ((PING && n > 0) ? 2 * n + 1 : n + 1) * (d + 1);
  endtask

  task automatic model_edge();
    if (m_mode == 1) begin
      lat_cnt++;
      m_step = 0;
      if (abort) begin
        m_mode = 0;
        m_busy = 0;
      end else begin
        void'(seq.pop_front());
        void'(dirq.pop_front());
        if (seq.size() == 0) begin
          m_mode = 2;
          m_done = 1;
          m_busy = 0;
        end else begin
          m_step  = (seq[0] != m_count) ? 1 : 0;
          m_count = seq[0];
          m_up    = dirq[0];
        end
      end
    end else begin
      m_done = 0;
      m_step = 0;
      if (start && !abort) begin
        build(int'(cfg_start), int'(cfg_end), int'(cfg_dwell));
        m_count = int'(cfg_start);
        m_up    = (cfg_end >= cfg_start) ? 1 : 0;
        m_busy  = 1;
        m_mode  = 1;
        lat_cnt = 0;
      end else begin
        m_mode = 0;
        m_busy = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(m_count));
    chk("up_down", 32'(up_down), 32'(m_up));
    chk("step", 32'(step), 32'(m_step));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    if (done === 1'b1)
      chk("done_latency", 32'(lat_cnt), 32'(lat_exp));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic scramble_cfg();
    cfg_start = W'($urandom);
    cfg_end   = W'($urandom);
    cfg_dwell = D'($urandom);
  endtask

  task automatic go(int s, int e, int d);
    cfg_start = W'(s);
    cfg_end   = W'(e);
    cfg_dwell = D'(d);
    start     = 1'b1;
    tick();
    start = 1'b0;
    scramble_cfg();
  endtask

  // asynchronous reset pulse between clock edges
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_start = '0;
    cfg_end   = '0;
    cfg_dwell = '0;
    model_reset();
    lat_cnt = 0;
    lat_exp = 0;
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    ticks(2);

    // reset mid-sweep, then a normal sweep
    go(1, 6, 3);
    ticks(6);
    async_reset();
    ticks(3);
    go(2, 5, 0);
    ticks(8);

    // down sweep with dwell
    go(6, 1, 2);
    ticks(22);

    // boundaries
    go(0, 7, 0);
    ticks(10);
    go(4, 4, 1);
    ticks(4);

    // abort at count 3
    go(1, 6, 1);
    for (int i = 0; i < 20; i++) begin
      if (m_count == 3) break;
      tick();
    end
    chk("abort_at3", 32'(count), 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ticks(3);

    // start ignored while busy
    go(0, 5, 0);
    start = 1'b1;
    scramble_cfg();
    ticks(2);
    start = 1'b0;
    ticks(6);

    // start+abort in idle
    start = 1'b1;
    abort = 1'b1;
    ticks(2);
    start = 1'b0;
    abort = 1'b0;
    tick();

    // back-to-back with start held
    cfg_start = 3'd1;
    cfg_end   = 3'd3;
    cfg_dwell = 4'd0;
    start     = 1'b1;
    ticks(14);
    start = 1'b0;
    ticks(6);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 23) == 0);
      cfg_start = W'($urandom);
      cfg_end   = W'($urandom);
      cfg_dwell = D'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) async_reset();
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    ticks(4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
